// File: rtl/frame_scanout_pkg.sv
// Shared constants and types for the frame scan-out path: framebuffer word
// and address widths, XGA raster timing, and the 12-bit pin color type.
package frame_scanout_pkg;

  localparam int COLOR_BITS = 4;
  localparam int ADDR_BITS  = 16;

  localparam int XGA_H_ACTIVE = 1024;
  localparam int XGA_H_FP     = 24;
  localparam int XGA_H_SYNC   = 136;
  localparam int XGA_H_BP     = 160;
  localparam int XGA_V_ACTIVE = 768;
  localparam int XGA_V_FP     = 3;
  localparam int XGA_V_SYNC   = 6;
  localparam int XGA_V_BP     = 29;
  localparam int XGA_SCALE_LOG2 = 2;

  // Counter state to pins: address register, 2-cycle frame store, RGB register.
  localparam int PIPE_DEPTH = 4;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  // Sub-pixel counters need at least one bit even when no scaling is applied.
  function automatic int sub_width(input int scale_log2);
    return (scale_log2 > 0) ? scale_log2 : 1;
  endfunction

endpackage

// File: rtl/frame_scanout_raster_timing.sv
// Raster counters plus sync, active-region and vblank decode. Everything
// decoded here is aligned with the registered counters (stage 0).
module frame_scanout_raster_timing
  import frame_scanout_pkg::*;
#(
  parameter int H_ACTIVE = XGA_H_ACTIVE,
  parameter int H_FP     = XGA_H_FP,
  parameter int H_SYNC   = XGA_H_SYNC,
  parameter int H_BP     = XGA_H_BP,
  parameter int V_ACTIVE = XGA_V_ACTIVE,
  parameter int V_FP     = XGA_V_FP,
  parameter int V_SYNC   = XGA_V_SYNC,
  parameter int V_BP     = XGA_V_BP,
  parameter int HW       = 11,
  parameter int VW       = 10
) (
  input  logic clk,
  input  logic rst_n,
  output logic h_active,
  output logic v_active,
  output logic active,
  output logic hs_n,
  output logic vs_n,
  output logic line_end,
  output logic frame_end,
  output logic vblank_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic [HW-1:0] hcount_q, hcount_d;
  logic [VW-1:0] vcount_q, vcount_d;

  assign line_end  = (int'(hcount_q) == H_TOTAL - 1);
  assign frame_end = line_end && (int'(vcount_q) == V_TOTAL - 1);
  assign h_active  = (int'(hcount_q) < H_ACTIVE);
  assign v_active  = (int'(vcount_q) < V_ACTIVE);
  assign active    = h_active && v_active;
  assign hs_n      = !((int'(hcount_q) >= H_ACTIVE + H_FP) &&
                       (int'(hcount_q) <  H_ACTIVE + H_FP + H_SYNC));
  assign vs_n      = !((int'(vcount_q) >= V_ACTIVE + V_FP) &&
                       (int'(vcount_q) <  V_ACTIVE + V_FP + V_SYNC));
  assign vblank_start = (hcount_q == '0) && (int'(vcount_q) == V_ACTIVE);

  // Next raster position: hcount every pixel, vcount at each line end.
  always_comb begin
    hcount_d = hcount_q + HW'(1);
    vcount_d = vcount_q;
    if (line_end) begin
      hcount_d = '0;
      vcount_d = frame_end ? '0 : vcount_q + VW'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hcount_q <= '0;
      vcount_q <= '0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
    end
  end

endmodule

// File: rtl/frame_scanout.sv
// Display-side scan-out: scaled framebuffer address generation without a
// multiplier, 2-cycle read latency absorption, grayscale color expansion and
// sync/blank delay matched to the pixel path.
module frame_scanout #(
  parameter int H_ACTIVE   = frame_scanout_pkg::XGA_H_ACTIVE,
  parameter int H_FP       = frame_scanout_pkg::XGA_H_FP,
  parameter int H_SYNC     = frame_scanout_pkg::XGA_H_SYNC,
  parameter int H_BP       = frame_scanout_pkg::XGA_H_BP,
  parameter int V_ACTIVE   = frame_scanout_pkg::XGA_V_ACTIVE,
  parameter int V_FP       = frame_scanout_pkg::XGA_V_FP,
  parameter int V_SYNC     = frame_scanout_pkg::XGA_V_SYNC,
  parameter int V_BP       = frame_scanout_pkg::XGA_V_BP,
  parameter int SCALE_LOG2 = frame_scanout_pkg::XGA_SCALE_LOG2,
  parameter int COLOR_BITS = frame_scanout_pkg::COLOR_BITS,
  parameter int ADDR_LEN   = frame_scanout_pkg::ADDR_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_LEN-1:0]   read_addr,
  input  logic [COLOR_BITS-1:0] read_data,
  output logic [3:0]            vga_r,
  output logic [3:0]            vga_g,
  output logic [3:0]            vga_b,
  output logic                  vga_hs,
  output logic                  vga_vs,
  output logic                  vga_blank,
  output logic                  vblank_start
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW       = $clog2(H_TOTAL);
  localparam int VW       = $clog2(V_TOTAL);
  localparam int FB_WIDTH = H_ACTIVE >> SCALE_LOG2;
  localparam int SUB_W    = frame_scanout_pkg::sub_width(SCALE_LOG2);
  localparam int DEPTH    = frame_scanout_pkg::PIPE_DEPTH;
  localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'((1 << SCALE_LOG2) - 1);
  localparam longint MAX_ADDR = longint'(FB_WIDTH) * longint'(V_ACTIVE >> SCALE_LOG2) - 1;

  // The last framebuffer address must be representable in ADDR_LEN bits.
  generate
    if (MAX_ADDR >= (longint'(1) << ADDR_LEN)) begin : g_addr_too_narrow
      $error("frame_scanout: ADDR_LEN cannot hold the last framebuffer address");
    end
  endgenerate

  logic h_active, v_active, active, hs_n, vs_n, line_end, frame_end;

  frame_scanout_raster_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HW(HW), .VW(VW)
  ) u_timing (
    .clk(clk), .rst_n(rst_n),
    .h_active(h_active), .v_active(v_active), .active(active),
    .hs_n(hs_n), .vs_n(vs_n), .line_end(line_end), .frame_end(frame_end),
    .vblank_start(vblank_start)
  );

  logic [SUB_W-1:0]    x_sub_q, x_sub_d, y_sub_q, y_sub_d;
  logic [ADDR_LEN-1:0] fb_x_q, fb_x_d, row_base_q, row_base_d;
  logic [ADDR_LEN-1:0] read_addr_q, read_addr_d;
  logic [DEPTH-1:0]    hs_pipe_q, hs_pipe_d, vs_pipe_q, vs_pipe_d;
  logic [DEPTH-1:0]    blank_pipe_q, blank_pipe_d;
  frame_scanout_pkg::rgb12_t rgb_q, rgb_d;
  logic [3:0]          chan;

  // Framebuffer codes are left-justified onto a 4-bit channel.
  generate
    if (COLOR_BITS >= 4) begin : g_chan_trunc
      assign chan = read_data[COLOR_BITS-1 -: 4];
    end else begin : g_chan_pad
      assign chan = {read_data, {(4 - COLOR_BITS){1'b0}}};
    end
  endgenerate

  // Incremental address state: x steps once per 2^S pixels, row_base steps
  // by one framebuffer row once per 2^S active lines.
  always_comb begin
    x_sub_d    = x_sub_q;
    fb_x_d     = fb_x_q;
    y_sub_d    = y_sub_q;
    row_base_d = row_base_q;
    if (line_end) begin
      x_sub_d = '0;
      fb_x_d  = '0;
    end else if (h_active) begin
      if (x_sub_q == SUB_MAX) begin
        x_sub_d = '0;
        fb_x_d  = fb_x_q + ADDR_LEN'(1);
      end else begin
        x_sub_d = x_sub_q + SUB_W'(1);
      end
    end
    if (frame_end) begin
      y_sub_d    = '0;
      row_base_d = '0;
    end else if (line_end && v_active) begin
      if (y_sub_q == SUB_MAX) begin
        y_sub_d    = '0;
        row_base_d = row_base_q + ADDR_LEN'(FB_WIDTH);
      end else begin
        y_sub_d = y_sub_q + SUB_W'(1);
      end
    end
  end

  // Stage 1 address, sync/blank delay line, and stage 4 color.
  always_comb begin
    read_addr_d  = active ? (row_base_q + fb_x_q) : '0;
    hs_pipe_d    = {hs_pipe_q[DEPTH-2:0], hs_n};
    vs_pipe_d    = {vs_pipe_q[DEPTH-2:0], vs_n};
    blank_pipe_d = {blank_pipe_q[DEPTH-2:0], !active};
    rgb_d        = '0;
    if (!blank_pipe_q[DEPTH-2]) begin
      rgb_d.r = chan;
      rgb_d.g = chan;
      rgb_d.b = chan;
    end
  end

  // All state; reset flushes the pipeline to blanked, sync-inactive levels.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_sub_q      <= '0;
      fb_x_q       <= '0;
      y_sub_q      <= '0;
      row_base_q   <= '0;
      read_addr_q  <= '0;
      hs_pipe_q    <= '1;
      vs_pipe_q    <= '1;
      blank_pipe_q <= '1;
      rgb_q        <= '0;
    end else begin
      x_sub_q      <= x_sub_d;
      fb_x_q       <= fb_x_d;
      y_sub_q      <= y_sub_d;
      row_base_q   <= row_base_d;
      read_addr_q  <= read_addr_d;
      hs_pipe_q    <= hs_pipe_d;
      vs_pipe_q    <= vs_pipe_d;
      blank_pipe_q <= blank_pipe_d;
      rgb_q        <= rgb_d;
    end
  end

  assign read_addr = read_addr_q;
  assign vga_r     = rgb_q.r;
  assign vga_g     = rgb_q.g;
  assign vga_b     = rgb_q.b;
  assign vga_hs    = hs_pipe_q[DEPTH-1];
  assign vga_vs    = vs_pipe_q[DEPTH-1];
  assign vga_blank = blank_pipe_q[DEPTH-1];

endmodule

// File: tb/tb_frame_scanout.sv
// Bench for frame_scanout: a small raster configuration checked against a
// hand-computed vector table plus a pin model, a mid-frame reset sequence,
// and an XGA instance for line timing and scaled addressing.
module tb_frame_scanout;
  import frame_scanout_pkg::*;

  localparam int S_HT    = 12;
  localparam int S_VT    = 7;
  localparam int S_FRAME = S_HT * S_VT;
  localparam int TBL_N   = 25;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // Clock.
  always #5 clk = ~clk;

  logic [ADDR_BITS-1:0]  s_addr, x_addr;
  logic [COLOR_BITS-1:0] s_data, x_data;
  logic [3:0] s_r, s_g, s_b, x_r, x_g, x_b;
  logic s_hs, s_vs, s_blank, s_vb, x_hs, x_vs, x_blank, x_vb;

  frame_scanout #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SCALE_LOG2(1)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .read_addr(s_addr), .read_data(s_data),
    .vga_r(s_r), .vga_g(s_g), .vga_b(s_b), .vga_hs(s_hs), .vga_vs(s_vs),
    .vga_blank(s_blank), .vblank_start(s_vb)
  );

  frame_scanout dut_x (
    .clk(clk), .rst_n(rst_n), .read_addr(x_addr), .read_data(x_data),
    .vga_r(x_r), .vga_g(x_g), .vga_b(x_b), .vga_hs(x_hs), .vga_vs(x_vs),
    .vga_blank(x_blank), .vblank_start(x_vb)
  );

  // Behavioural frame stores with 2-cycle read latency, mem[a] = a[3:0].
  logic [COLOR_BITS-1:0] s_d1 = '0, s_d2 = '0, x_d1 = '0, x_d2 = '0;
  always @(posedge clk) begin
    s_d1 <= s_addr[3:0];
    s_d2 <= s_d1;
    x_d1 <= x_addr[3:0];
    x_d2 <= x_d1;
  end
  assign s_data = s_d2;
  assign x_data = x_d2;

  typedef struct {
    int         cyc;
    int         addr;
    logic       blank;
    logic [3:0] pix;
    logic       hs;
    logic       vs;
  } vec_t;

  vec_t tbl [TBL_N];
  logic [6:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    int h, v, fall1, fall2, hs_low, blank_low, vs_low;
    logic prev_hs, e_blank, e_hs, e_vs;
    logic [3:0] e_pix;
    logic [6:0] ent;

    // {cycle after reset, read_addr, blank, pixel code, hs, vs}
    tbl[0]  = '{0,  0, 1'b1, 4'd0, 1'b1, 1'b1};
    tbl[1]  = '{1,  0, 1'b1, 4'd0, 1'b1, 1'b1};
    tbl[2]  = '{2,  0, 1'b1, 4'd0, 1'b1, 1'b1};
    tbl[3]  = '{3,  1, 1'b1, 4'd0, 1'b1, 1'b1};
    tbl[4]  = '{4,  1, 1'b0, 4'd0, 1'b1, 1'b1};
    tbl[5]  = '{8,  3, 1'b0, 4'd2, 1'b1, 1'b1};
    tbl[6]  = '{9,  0, 1'b0, 4'd2, 1'b1, 1'b1};
    tbl[7]  = '{11, 0, 1'b0, 4'd3, 1'b1, 1'b1};
    tbl[8]  = '{12, 0, 1'b1, 4'd0, 1'b1, 1'b1};
    tbl[9]  = '{13, 0, 1'b1, 4'd0, 1'b0, 1'b1};
    tbl[10] = '{14, 0, 1'b1, 4'd0, 1'b0, 1'b1};
    tbl[11] = '{15, 1, 1'b1, 4'd0, 1'b1, 1'b1};
    tbl[12] = '{25, 4, 1'b1, 4'd0, 1'b0, 1'b1};
    tbl[13] = '{29, 6, 1'b0, 4'd4, 1'b1, 1'b1};
    tbl[14] = '{37, 4, 1'b1, 4'd0, 1'b0, 1'b1};
    tbl[15] = '{40, 5, 1'b0, 4'd4, 1'b1, 1'b1};
    tbl[16] = '{44, 7, 1'b0, 4'd6, 1'b1, 1'b1};
    tbl[17] = '{45, 0, 1'b0, 4'd6, 1'b1, 1'b1};
    tbl[18] = '{48, 0, 1'b1, 4'd0, 1'b1, 1'b1};
    tbl[19] = '{66, 0, 1'b1, 4'd0, 1'b1, 1'b0};
    tbl[20] = '{76, 0, 1'b1, 4'd0, 1'b1, 1'b1};
    tbl[21] = '{85, 0, 1'b1, 4'd0, 1'b0, 1'b1};
    tbl[22] = '{87, 1, 1'b1, 4'd0, 1'b1, 1'b1};
    tbl[23] = '{88, 1, 1'b0, 4'd0, 1'b1, 1'b1};
    tbl[24] = '{92, 3, 1'b0, 4'd2, 1'b1, 1'b1};

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Phase 1: small raster, cycle 0 has the counters at (0,0).
    for (int n = 0; n <= 197; n++) begin
      for (int k = 0; k < TBL_N; k++) begin
        if (tbl[k].cyc == n) begin
          check($sformatf("tbl_addr@%0d", n), 32'(s_addr), 32'(tbl[k].addr));
          check($sformatf("tbl_blank@%0d", n), 32'(s_blank), 32'(tbl[k].blank));
          check($sformatf("tbl_rgb@%0d", n), 32'({s_r, s_g, s_b}),
                32'({tbl[k].pix, tbl[k].pix, tbl[k].pix}));
          check($sformatf("tbl_hs@%0d", n), 32'(s_hs), 32'(tbl[k].hs));
          check($sformatf("tbl_vs@%0d", n), 32'(s_vs), 32'(tbl[k].vs));
        end
      end
      check($sformatf("vblank@%0d", n), 32'(s_vb), 32'((n % S_FRAME) == 48));

      // Expected pins for the counter position one cycle back, due 3 cycles on.
      if (n >= 1) begin
        h = (n - 1) % S_HT;
        v = ((n - 1) / S_HT) % S_VT;
        e_blank = !(h < 8 && v < 4);
        e_hs    = !(h >= 9 && h < 11);
        e_vs    = !(v == 5);
        e_pix   = e_blank ? 4'd0 : s_addr[3:0];
        exp_q.push_back({e_blank, e_hs, e_vs, e_pix});
      end
      if (n >= 4) begin
        if (exp_q.size() == 0) begin
          check($sformatf("sb_underflow@%0d", n), 32'd0, 32'd1);
        end else begin
          ent = exp_q.pop_front();
          check($sformatf("sb_pins@%0d", n), 32'({s_blank, s_hs, s_vs, s_r, s_g, s_b}),
                32'({ent[6:4], ent[3:0], ent[3:0], ent[3:0]}));
        end
      end

      if (n == 197) begin
        check("pre_reset_h", 32'(dut_s.u_timing.hcount_q), 32'd5);
        check("pre_reset_v", 32'(dut_s.u_timing.vcount_q), 32'd2);
        rst_n = 1'b0;
      end
      @(negedge clk);
    end
    rst_n = 1'b1;

    // Phase 2: one-cycle reset at (5,2) just applied; c counts from the reset edge.
    fall1 = -1; fall2 = -1; hs_low = 0; blank_low = 0; vs_low = 0;
    prev_hs = 1'b1;
    for (int c = 0; c <= 5500; c++) begin
      if (c == 0) begin
        check("rst_h", 32'(dut_s.u_timing.hcount_q), 32'd0);
        check("rst_v", 32'(dut_s.u_timing.vcount_q), 32'd0);
        check("rst_addr", 32'(s_addr), 32'd0);
        check("rst_rgb", 32'({s_r, s_g, s_b}), 32'd0);
      end
      if (c <= 3) check($sformatf("rst_blank@%0d", c), 32'(s_blank), 32'd1);
      if (c == 1) check("rst_addr1", 32'(s_addr), 32'd0);
      if (c == 3) check("rst_addr3", 32'(s_addr), 32'd1);
      if (c == 4) begin
        check("rst_blank4", 32'(s_blank), 32'd0);
        check("rst_pix0", 32'({s_r, s_g, s_b}), 32'd0);
      end
      if (c == 8) check("rst_pix8", 32'({s_r, s_g, s_b}), 32'h222);

      if (c == 1024) check("xga_addr_eol", 32'(x_addr), 32'd255);
      if (c == 1025) check("xga_addr_blank", 32'(x_addr), 32'd0);
      if (c == 1027) check("xga_pix_eol", 32'({x_r, x_g, x_b}), 32'hfff);
      if (c == 4041) check("xga_addr_l3", 32'(x_addr), 32'd2);
      if (c == 5381) check("xga_addr_l4", 32'(x_addr), 32'd257);

      if (prev_hs && !x_hs) begin
        if (fall1 < 0) fall1 = c;
        else if (fall2 < 0) fall2 = c;
      end
      if (fall1 >= 0 && fall2 < 0) begin
        if (!x_hs) hs_low++;
        if (!x_blank) blank_low++;
      end
      if (!x_vs) vs_low++;
      prev_hs = x_hs;
      @(negedge clk);
    end
    check("xga_hs_first_fall", 32'(fall1), 32'd1052);
    check("xga_line_period", 32'(fall2 - fall1), 32'd1344);
    check("xga_hs_width", 32'(hs_low), 32'd136);
    check("xga_active_per_line", 32'(blank_low), 32'd1024);
    check("xga_vs_idle", 32'(vs_low), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
